// File: rtl/mult_pkg.sv
// Shared constants for the 4x4 unsigned array multiplier.
// MULT4_PIPE_EN selects the two-stage build, whose latency is 2 cycles instead of 1.
package mult_pkg;

  localparam int MULT4_WIDTH  = 4;
  localparam int MULT4_PROD_W = 8;

`ifdef MULT4_PIPE_EN
  localparam int MULT4_LAT = 2;
`else
  localparam int MULT4_LAT = 1;
`endif

endpackage

// File: rtl/multiplier_4bit_full_adder.sv
// One-bit full adder cell used throughout the multiplier array.
module full_adder (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = x ^ y ^ cin;
  assign cout = (x & y) | (cin & (x ^ y));

endmodule

// File: rtl/multiplier_4bit.sv
// Unsigned 4x4 array multiplier with a registered 8-bit product and valid.
// The MULT4_PIPE_EN macro adds a register stage after row 1, giving 2-cycle latency.
module multiplier_4bit
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT4_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   M,
  output logic                 out_valid
);

  logic [3:0] pp0_s, pp1_s, pp2_s, pp3_s;
  logic [3:0] r1_y_s;
  logic [3:0] r1_s_s, r2_s_s, r3_s_s;
  logic [4:1] r1_c_s, r2_c_s, r3_c_s;
  logic [3:0] acc1_s, acc2_s;
  logic [1:0] lo1_s;

  logic [3:0] acc_src_s;
  logic [1:0] lo_src_s;
  logic [3:0] a_src_s;
  logic [1:0] bhi_src_s;
  logic       valid_src_s;

  logic [7:0] prod_s;
  logic [7:0] m_d, m_q;
  logic       out_valid_d, out_valid_q;

  assign pp0_s  = a & {4{b[0]}};
  assign pp1_s  = a & {4{b[1]}};
  assign r1_y_s = {1'b0, pp0_s[3:1]};

  // Each row adds the next partial product to the upper bits of the running sum.
  for (genvar j = 0; j < 4; j++) begin : g_row1
    if (j == 0) begin : g_first
      full_adder u_fa (.x(pp1_s[j]), .y(r1_y_s[j]), .cin(1'b0),
                       .s(r1_s_s[j]), .cout(r1_c_s[j+1]));
    end else begin : g_rest
      full_adder u_fa (.x(pp1_s[j]), .y(r1_y_s[j]), .cin(r1_c_s[j]),
                       .s(r1_s_s[j]), .cout(r1_c_s[j+1]));
    end
  end

  assign acc1_s = {r1_c_s[4], r1_s_s[3:1]};
  assign lo1_s  = {r1_s_s[0], pp0_s[0]};

`ifdef MULT4_PIPE_EN
  logic [3:0] st_acc_d, st_acc_q;
  logic [1:0] st_lo_d,  st_lo_q;
  logic [3:0] st_a_d,   st_a_q;
  logic [1:0] st_bhi_d, st_bhi_q;
  logic       st_valid_d, st_valid_q;

  // Mid-array stage: row-1 sum, settled low bits, multiplicand and b[3:2].
  always_comb begin
    st_acc_d   = acc1_s;
    st_lo_d    = lo1_s;
    st_a_d     = a;
    st_bhi_d   = b[3:2];
    st_valid_d = in_valid;
  end

  // Mid-array stage register, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_acc_q   <= 4'h0;
      st_lo_q    <= 2'b00;
      st_a_q     <= 4'h0;
      st_bhi_q   <= 2'b00;
      st_valid_q <= 1'b0;
    end else begin
      st_acc_q   <= st_acc_d;
      st_lo_q    <= st_lo_d;
      st_a_q     <= st_a_d;
      st_bhi_q   <= st_bhi_d;
      st_valid_q <= st_valid_d;
    end
  end

  assign acc_src_s   = st_acc_q;
  assign lo_src_s    = st_lo_q;
  assign a_src_s     = st_a_q;
  assign bhi_src_s   = st_bhi_q;
  assign valid_src_s = st_valid_q;
`else
  assign acc_src_s   = acc1_s;
  assign lo_src_s    = lo1_s;
  assign a_src_s     = a;
  assign bhi_src_s   = b[3:2];
  assign valid_src_s = in_valid;
`endif

  assign pp2_s = a_src_s & {4{bhi_src_s[0]}};
  assign pp3_s = a_src_s & {4{bhi_src_s[1]}};

  for (genvar j = 0; j < 4; j++) begin : g_row2
    if (j == 0) begin : g_first
      full_adder u_fa (.x(pp2_s[j]), .y(acc_src_s[j]), .cin(1'b0),
                       .s(r2_s_s[j]), .cout(r2_c_s[j+1]));
    end else begin : g_rest
      full_adder u_fa (.x(pp2_s[j]), .y(acc_src_s[j]), .cin(r2_c_s[j]),
                       .s(r2_s_s[j]), .cout(r2_c_s[j+1]));
    end
  end

  assign acc2_s = {r2_c_s[4], r2_s_s[3:1]};

  // The last row is the ripple-carry adder that yields the upper product bits.
  for (genvar j = 0; j < 4; j++) begin : g_row3
    if (j == 0) begin : g_first
      full_adder u_fa (.x(pp3_s[j]), .y(acc2_s[j]), .cin(1'b0),
                       .s(r3_s_s[j]), .cout(r3_c_s[j+1]));
    end else begin : g_rest
      full_adder u_fa (.x(pp3_s[j]), .y(acc2_s[j]), .cin(r3_c_s[j]),
                       .s(r3_s_s[j]), .cout(r3_c_s[j+1]));
    end
  end

  assign prod_s = {r3_c_s[4], r3_s_s, r2_s_s[0], lo_src_s};

  // Next-state values of the output register.
  always_comb begin
    m_d         = prod_s;
    out_valid_d = valid_src_s;
  end

  // Output register; reset takes priority over all other inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_q         <= 8'h00;
      out_valid_q <= 1'b0;
    end else begin
      m_q         <= m_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign M         = m_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_multiplier_4bit.sv
// Directed bench for multiplier_4bit; a latency-aware pipeline model carries
// hand-computed products so the same vectors serve both builds.
module tb_multiplier_4bit;
  import mult_pkg::*;

  localparam int LAT = MULT4_LAT;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] a = 4'h0;
  logic [3:0] b = 4'h0;
  logic [7:0] M;
  logic       out_valid;

  int n_vec  = 0;
  int n_miss = 0;

  logic [7:0] exp_m_pipe [LAT];
  logic       exp_v_pipe [LAT];

  multiplier_4bit dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .a(a), .b(b), .M(M), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  // Apply one cycle of stimulus; exp is the hand-computed product of a_i*b_i.
  task automatic step(input string tag, input logic [3:0] a_i, input logic [3:0] b_i,
                      input logic v_i, input logic r_i, input logic [7:0] exp);
    a = a_i; b = b_i; in_valid = v_i; rst = r_i;
    @(posedge clk);
    if (r_i) begin
      for (int i = 0; i < LAT; i++) begin
        exp_m_pipe[i] = 8'h00;
        exp_v_pipe[i] = 1'b0;
      end
    end else begin
      for (int i = LAT - 1; i > 0; i--) begin
        exp_m_pipe[i] = exp_m_pipe[i-1];
        exp_v_pipe[i] = exp_v_pipe[i-1];
      end
      exp_m_pipe[0] = exp;
      exp_v_pipe[0] = v_i;
    end
    #1;
    chk({tag, ".M"}, {24'h0, M}, {24'h0, exp_m_pipe[LAT-1]});
    chk({tag, ".vld"}, {31'h0, out_valid}, {31'h0, exp_v_pipe[LAT-1]});
  endtask

  initial begin
    for (int i = 0; i < LAT; i++) begin
      exp_m_pipe[i] = 8'h00;
      exp_v_pipe[i] = 1'b0;
    end

    // Reset held two cycles with max operands driven
    step("rst0", 4'hF, 4'hF, 1'b1, 1'b1, 8'hE1);
    step("rst1", 4'hF, 4'hF, 1'b1, 1'b1, 8'hE1);
    step("rel",  4'hF, 4'hF, 1'b1, 1'b0, 8'hE1);

    // Directed vectors
    step("zero1", 4'b0001, 4'b0000, 1'b1, 1'b0, 8'h00);
    step("zero2", 4'b0101, 4'b0000, 1'b1, 1'b0, 8'h00);
    step("zeroa", 4'b0000, 4'b1011, 1'b1, 1'b0, 8'h00);
    step("mid",   4'b0101, 4'b0101, 1'b1, 1'b0, 8'h19);
    step("max",   4'b1111, 4'b1111, 1'b1, 1'b0, 8'hE1);
    step("a1",    4'b0001, 4'hF,    1'b1, 1'b0, 8'h0F);
    step("a1b9",  4'b0001, 4'h9,    1'b1, 1'b0, 8'h09);
    step("7x9",   4'h7,    4'h9,    1'b1, 1'b0, 8'h3F);
    step("ex8",   4'hE,    4'h8,    1'b1, 1'b0, 8'h70);
    step("cx3",   4'hC,    4'h3,    1'b1, 1'b0, 8'h24);

    // Valid gap: out_valid follows 1,0,1; M still tracks a*b when invalid
    step("gap1", 4'h3, 4'h4, 1'b1, 1'b0, 8'h0C);
    step("gap0", 4'h6, 4'h6, 1'b0, 1'b0, 8'h24);
    step("gap2", 4'hA, 4'hB, 1'b1, 1'b0, 8'h6E);

    // Single-cycle reset mid-stream
    step("mrs0", 4'h9, 4'h9, 1'b1, 1'b0, 8'h51);
    step("mrs1", 4'hD, 4'hD, 1'b1, 1'b1, 8'hA9);
    step("mrs2", 4'h2, 4'hB, 1'b1, 1'b0, 8'h16);
    step("mrs3", 4'hF, 4'h2, 1'b1, 1'b0, 8'h1E);

    // All 256 operand pairs back-to-back
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        logic [7:0] p;
        p = 8'(ia * ib);
        step("exh", 4'(ia), 4'(ib), 1'b1, 1'b0, p);
      end
    end

    // Drain the pipeline
    for (int i = 0; i < LAT; i++) begin
      step("drain", 4'h0, 4'h0, 1'b0, 1'b0, 8'h00);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
